// File: rtl/hi_lo_muldiv_pkg.sv
// Shared encodings and helpers for the HI/LO iterative multiply/divide unit.
package hi_lo_muldiv_pkg;

    localparam int WIDTH_DEF = 32;

    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        FIX  = 2'b10
    } state_t;

    function automatic logic op_is_div(input op_t op);
        return op[1];
    endfunction

    function automatic logic op_is_signed(input op_t op);
        return ~op[0];
    endfunction

endpackage

// File: rtl/hi_lo_muldiv_if.sv
// Execute-stage request/response bundle between the pipeline and the mul/div unit.
interface hi_lo_muldiv_if #(
    parameter int WIDTH = hi_lo_muldiv_pkg::WIDTH_DEF
);
    logic                      start;
    hi_lo_muldiv_pkg::op_t     op;
    logic [WIDTH-1:0]          a;
    logic [WIDTH-1:0]          b;
    logic                      mthi_en;
    logic                      mtlo_en;
    logic [WIDTH-1:0]          mt_data;
    logic                      flush;
    logic                      busy;
    logic                      done;
    logic [WIDTH-1:0]          hi;
    logic [WIDTH-1:0]          lo;

    modport master (
        output start, op, a, b, mthi_en, mtlo_en, mt_data, flush,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, a, b, mthi_en, mtlo_en, mt_data, flush,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/hi_lo_muldiv_step.sv
// One iteration of shift-add multiply or restoring divide on unsigned magnitudes.
module hi_lo_muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic             is_div,
    input  logic [WIDTH-1:0] acc,
    input  logic [WIDTH-1:0] mq,
    input  logic [WIDTH-1:0] dvs,
    output logic [WIDTH-1:0] acc_nx,
    output logic [WIDTH-1:0] mq_nx
);
    logic [WIDTH:0] sum;
    logic [WIDTH:0] rsh;
    logic [WIDTH:0] diff;

    always_comb begin
        sum    = {1'b0, acc} + {1'b0, (mq[0] ? dvs : {WIDTH{1'b0}})};
        rsh    = {acc, mq[WIDTH-1]};
        diff   = rsh - {1'b0, dvs};
        acc_nx = sum[WIDTH:1];
        mq_nx  = {sum[0], mq[WIDTH-1:1]};
        if (is_div) begin
            // partial remainder stays below the divisor, so the top diff bit is the borrow
            if (diff[WIDTH]) begin
                acc_nx = rsh[WIDTH-1:0];
                mq_nx  = {mq[WIDTH-2:0], 1'b0};
            end else begin
                acc_nx = diff[WIDTH-1:0];
                mq_nx  = {mq[WIDTH-2:0], 1'b1};
            end
        end
    end
endmodule

// File: rtl/hi_lo_muldiv.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning HI/LO; one iteration per clock.
// state | meaning
// IDLE  | accept start or MTHI/MTLO writes
// RUN   | WIDTH shift-add / restoring-divide iterations
// FIX   | sign correction and HI/LO writeback
module hi_lo_muldiv
    import hi_lo_muldiv_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst,
    hi_lo_muldiv_if.slave    bus
);
    localparam int CW = $clog2(WIDTH);

    state_t             state;
    logic [CW-1:0]      cnt;
    logic [WIDTH-1:0]   acc;
    logic [WIDTH-1:0]   mq;
    logic [WIDTH-1:0]   dvs;
    logic               is_div;
    logic               neg_lo;
    logic               neg_hi;
    logic               div_zero;
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;
    logic               done_q;

    logic [WIDTH-1:0]   acc_nx;
    logic [WIDTH-1:0]   mq_nx;
    logic               sa;
    logic               sb;
    logic               op_div;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [2*WIDTH-1:0] prod;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;

    hi_lo_muldiv_step #(.WIDTH(WIDTH)) u_step (
        .is_div (is_div),
        .acc    (acc),
        .mq     (mq),
        .dvs    (dvs),
        .acc_nx (acc_nx),
        .mq_nx  (mq_nx)
    );

    always_comb begin
        sa       = op_is_signed(bus.op) & bus.a[WIDTH-1];
        sb       = op_is_signed(bus.op) & bus.b[WIDTH-1];
        op_div   = op_is_div(bus.op);
        a_mag    = sa ? -bus.a : bus.a;
        b_mag    = sb ? -bus.b : bus.b;
        prod     = {acc, mq};
        prod_fix = neg_lo ? -prod : prod;
        // divide by zero leaves the remainder equal to the dividend; only LO is forced
        quo_fix  = div_zero ? {WIDTH{1'b1}} : (neg_lo ? -mq : mq);
        rem_fix  = neg_hi ? -acc : acc;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            acc      <= '0;
            mq       <= '0;
            dvs      <= '0;
            is_div   <= 1'b0;
            neg_lo   <= 1'b0;
            neg_hi   <= 1'b0;
            div_zero <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (!bus.flush) begin
                        if (bus.start) begin
                            acc      <= '0;
                            cnt      <= '0;
                            mq       <= op_div ? a_mag : b_mag;
                            dvs      <= op_div ? b_mag : a_mag;
                            is_div   <= op_div;
                            neg_lo   <= sa ^ sb;
                            neg_hi   <= sa & op_div;
                            div_zero <= (bus.b == '0);
                            state    <= RUN;
                        end else begin
                            if (bus.mthi_en) hi_q <= bus.mt_data;
                            if (bus.mtlo_en) lo_q <= bus.mt_data;
                        end
                    end
                end
                RUN: begin
                    if (bus.flush) begin
                        state <= IDLE;
                    end else begin
                        acc <= acc_nx;
                        mq  <= mq_nx;
                        cnt <= cnt + CW'(1);
                        if (cnt == CW'(WIDTH-1)) state <= FIX;
                    end
                end
                FIX: begin
                    state <= IDLE;
                    if (!bus.flush) begin
                        if (is_div) begin
                            hi_q <= rem_fix;
                            lo_q <= quo_fix;
                        end else begin
                            hi_q <= prod_fix[2*WIDTH-1:WIDTH];
                            lo_q <= prod_fix[WIDTH-1:0];
                        end
                        done_q <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy = (state != IDLE);
    assign bus.done = done_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;
endmodule

// File: tb/tb_hi_lo_muldiv.sv
// Directed bench for hi_lo_muldiv: arithmetic vectors, latency, MT writes, flush and reset.
module tb_hi_lo_muldiv;
    import hi_lo_muldiv_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   n_chk  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    hi_lo_muldiv_if #(.WIDTH(32)) bus ();

    hi_lo_muldiv #(.WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        bus.start   = 1'b0;
        bus.op      = OP_MULT;
        bus.a       = '0;
        bus.b       = '0;
        bus.mthi_en = 1'b0;
        bus.mtlo_en = 1'b0;
        bus.mt_data = '0;
        bus.flush   = 1'b0;
    endtask

    // one-cycle start pulse; returns at the negedge after the launching edge
    task automatic launch(input op_t op, input logic [31:0] a, input logic [31:0] b,
                          input logic mthi, input logic [31:0] data);
        @(negedge clk);
        bus.start   = 1'b1;
        bus.op      = op;
        bus.a       = a;
        bus.b       = b;
        bus.mthi_en = mthi;
        bus.mt_data = data;
        @(negedge clk);
        clear_inputs();
    endtask

    task automatic finish_op(input string tag, input logic [31:0] eh, input logic [31:0] el);
        int nb = 0;
        int guard = 0;
        while (!bus.done && guard < 100) begin
            if (bus.busy) nb++;
            @(negedge clk);
            guard++;
        end
        chk({tag, "_done"}, {63'd0, bus.done}, 64'd1);
        chk({tag, "_busy_cycles"}, 64'(nb), 64'd33);
        chk({tag, "_busy_after"}, {63'd0, bus.busy}, 64'd0);
        chk({tag, "_hi"}, {32'd0, bus.hi}, {32'd0, eh});
        chk({tag, "_lo"}, {32'd0, bus.lo}, {32'd0, el});
        @(negedge clk);
        chk({tag, "_done_pulse"}, {63'd0, bus.done}, 64'd0);
    endtask

    task automatic run_op(input string tag, input op_t op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el);
        launch(op, a, b, 1'b0, 32'd0);
        finish_op(tag, eh, el);
    endtask

    task automatic mt_write(input logic hen, input logic len, input logic [31:0] data);
        @(negedge clk);
        bus.mthi_en = hen;
        bus.mtlo_en = len;
        bus.mt_data = data;
        @(negedge clk);
        clear_inputs();
    endtask

    initial begin
        int ndone;
        rst = 1'b1;
        clear_inputs();
        repeat (2) @(negedge clk);
        chk("rst_hi", {32'd0, bus.hi}, 64'd0);
        chk("rst_lo", {32'd0, bus.lo}, 64'd0);
        chk("rst_busy", {63'd0, bus.busy}, 64'd0);
        chk("rst_done", {63'd0, bus.done}, 64'd0);
        rst = 1'b0;

        run_op("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
        run_op("mult_neg",  OP_MULT,  32'hFFFF_FFFD, 32'd7,        32'hFFFF_FFFF, 32'hFFFF_FFEB);
        run_op("mult_nn",   OP_MULT,  32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'h0000_0000, 32'h0000_0006);
        run_op("div_neg",   OP_DIV,   32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("div_ovf",   OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);
        run_op("divu_zero", OP_DIVU,  32'd100,       32'd0,        32'h0000_0064, 32'hFFFF_FFFF);
        run_op("div_zero",  OP_DIV,   32'hFFFF_FFFB, 32'd0,        32'hFFFF_FFFB, 32'hFFFF_FFFF);
        run_op("divu_50_3", OP_DIVU,  32'd50,        32'd3,        32'd2,         32'd16);

        mt_write(1'b1, 1'b1, 32'hA5A5_A5A5);
        chk("mt_both_hi", {32'd0, bus.hi}, 64'hA5A5_A5A5);
        chk("mt_both_lo", {32'd0, bus.lo}, 64'hA5A5_A5A5);
        mt_write(1'b1, 1'b0, 32'h1111_1111);
        mt_write(1'b0, 1'b1, 32'h2222_2222);
        chk("mthi_pre", {32'd0, bus.hi}, 64'h1111_1111);
        chk("mtlo_pre", {32'd0, bus.lo}, 64'h2222_2222);

        // start plus MT write while busy is dropped, then flush aborts
        launch(OP_DIVU, 32'd50, 32'd3, 1'b0, 32'd0);
        repeat (8) @(negedge clk);
        bus.start   = 1'b1;
        bus.op      = OP_MULTU;
        bus.a       = 32'd9;
        bus.b       = 32'd9;
        bus.mthi_en = 1'b1;
        bus.mt_data = 32'hDEAD_BEEF;
        @(negedge clk);
        clear_inputs();
        chk("busy_ign_busy", {63'd0, bus.busy}, 64'd1);
        chk("busy_ign_hi", {32'd0, bus.hi}, 64'h1111_1111);
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        chk("flush_busy", {63'd0, bus.busy}, 64'd0);
        chk("flush_hi", {32'd0, bus.hi}, 64'h1111_1111);
        chk("flush_lo", {32'd0, bus.lo}, 64'h2222_2222);
        ndone = 0;
        for (int i = 0; i < 40; i++) begin
            if (bus.done) ndone++;
            @(negedge clk);
        end
        chk("flush_no_done", 64'(ndone), 64'd0);
        chk("flush_hi_late", {32'd0, bus.hi}, 64'h1111_1111);
        mt_write(1'b0, 1'b1, 32'h5);
        chk("mtlo_5_lo", {32'd0, bus.lo}, 64'h5);
        chk("mtlo_5_hi", {32'd0, bus.hi}, 64'h1111_1111);

        // flush in IDLE suppresses start and MT writes
        @(negedge clk);
        bus.flush   = 1'b1;
        bus.start   = 1'b1;
        bus.op      = OP_MULTU;
        bus.mtlo_en = 1'b1;
        bus.mt_data = 32'h77;
        @(negedge clk);
        clear_inputs();
        chk("idle_flush_busy", {63'd0, bus.busy}, 64'd0);
        chk("idle_flush_lo", {32'd0, bus.lo}, 64'h5);

        // start wins over a simultaneous MTHI in IDLE
        launch(OP_DIVU, 32'd50, 32'd3, 1'b1, 32'hDEAD_BEEF);
        chk("start_wins_busy", {63'd0, bus.busy}, 64'd1);
        chk("start_wins_hi", {32'd0, bus.hi}, 64'h1111_1111);
        finish_op("start_wins", 32'd2, 32'd16);

        // asynchronous reset in the middle of a MULT
        launch(OP_MULT, 32'hFFFF_FFFD, 32'd7, 1'b0, 32'd0);
        repeat (19) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("mid_rst_hi", {32'd0, bus.hi}, 64'd0);
        chk("mid_rst_lo", {32'd0, bus.lo}, 64'd0);
        chk("mid_rst_busy", {63'd0, bus.busy}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        run_op("post_rst_divu", OP_DIVU, 32'd50, 32'd3, 32'd2, 32'd16);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/hi_lo_muldiv.md
Name: hi_lo_muldiv

Overview:
- Iterative multiply/divide unit in the execute stage. It owns the architectural HI/LO registers and feeds the Hi/Lo inputs of the memory stage.
- Executes MULT, MULTU, DIV and DIVU over multiple cycles, one iteration per cycle. It also services MTHI/MTLO writes.
- Exposes Busy so the hazard unit can stall any MFHI/MFLO or new mul/div instruction until the result is ready.

Parameters:
- WIDTH, 32, operand width; HI and LO are each WIDTH bits. Iteration count equals WIDTH.

Ports:
- Clk  input  1  pipeline clock; all state changes on the rising edge.
- Rst  input  1  asynchronous, active-high reset.
- Start  input  1  launch the operation selected by Op. Sampled only in IDLE.
- Op  input  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- A  input  WIDTH  rs operand (multiplicand / dividend).
- B  input  WIDTH  rt operand (multiplier / divisor).
- MthiEn  input  1  write MtData into HI (MTHI).
- MtloEn  input  1  write MtData into LO (MTLO).
- MtData  input  WIDTH  data for MTHI/MTLO.
- Flush  input  1  abort the in-flight operation; the pipeline flushes the issuing instruction.
- Busy  output  1  high whenever state is not IDLE.
- Done  output  1  one-cycle pulse; HI/LO were just updated by a mul/div.
- Hi  output  WIDTH  HI register.
- Lo  output  WIDTH  LO register.

Behaviour:
- Reset (asynchronous): state=IDLE, Hi=0, Lo=0, Busy=0, Done=0, iteration counter=0. Reset mid-operation discards all work.
- States:
  - IDLE: accepts Start or MT writes.
  - RUN: WIDTH iterations.
  - FIX: sign correction and HI/LO writeback.
- Edge E0, IDLE with Start=1:
  - Latch operand magnitudes. For signed ops (MULT, DIV) take the absolute value of each negative operand.
  - Record the result signs. For MULT: product sign = sA^sB. For DIV: quotient sign = sA^sB, remainder sign = sA.
  - Clear the accumulator and counter; go to RUN.
- RUN, multiply: shift-add over the {accumulator, multiplier} 2*WIDTH register, one multiplier bit per edge.
- RUN, divide: restoring divide, one quotient bit per edge.
- After WIDTH RUN edges (E1..E32 for WIDTH=32), go to FIX.
- FIX (E33):
  - Negate the product, quotient or remainder per the recorded signs.
  - Write HI = upper word or remainder; LO = lower word or quotient.
  - Go to IDLE.
- Latency: Busy high in the 33 cycles following E0. Hi/Lo hold the new values and Done=1 in the cycle after E33. Busy=0 in that same cycle.
- Done is registered, high exactly one cycle per completed operation, never for MT writes or aborted operations.
- Divide by zero (B=0, DIV or DIVU): runs the full latency. Result is Lo=all-ones; Hi=A, the original signed/unsigned value unchanged.
- DIV overflow (A=0x80000000, B=0xFFFFFFFF): Lo=0x80000000, Hi=0. This is the natural magnitude result; no trap.
- Start while Busy: ignored. Hi/Lo writes while Busy: ignored (dropped). The hazard unit must stall these.
- IDLE with Start and an MT enable both high: Start wins; the MT write is dropped.
- IDLE with MthiEn and MtloEn both high: both registers are written with MtData.
- Flush while Busy: state=IDLE on the next edge. Hi/Lo keep their pre-operation values; Done stays 0.
- Flush in IDLE: suppresses Start and MT writes in that cycle.
- Flush and Rst together: Rst dominates.
- Hi/Lo change only at the FIX edge, on an MT write edge, or on reset. Intermediate values are never visible on Hi/Lo.

Decomposition:
- Shared package holds:
  - Op encodings: OP_MULT=2'b00, OP_MULTU=2'b01, OP_DIV=2'b10, OP_DIVU=2'b11.
  - State encodings IDLE/RUN/FIX.
  - Default WIDTH.
- One combinational sub-module, muldiv_step, computes a single iteration: next accumulator/remainder and next quotient/multiplier bits, given the op type.
- The top level holds the FSM, counter, sign bookkeeping, FIX negation and HI/LO registers.

Test Plan:
- MULTU A=0xFFFFFFFF, B=0xFFFFFFFF -> Busy for 33 cycles; then Hi=0xFFFFFFFE, Lo=0x00000001, Done pulse for 1 cycle.
- MULT A=0xFFFFFFFD (-3), B=7 -> Hi=0xFFFFFFFF, Lo=0xFFFFFFEB (-21).
- DIV A=0xFFFFFFF9 (-7), B=2 -> Lo=0xFFFFFFFD, Hi=0xFFFFFFFF. Then DIV A=0x80000000, B=0xFFFFFFFF -> Lo=0x80000000, Hi=0.
- DIVU A=100, B=0 -> Lo=0xFFFFFFFF, Hi=0x00000064, Done after standard latency.
- Hi/Lo preloaded to 0x11111111 and 0x22222222:
  - Start DIVU 50/3. At cycle 10 assert Start (MULTU) plus MthiEn with MtData=0xDEADBEEF -> both ignored.
  - Assert Flush at cycle 12 -> Busy=0 next cycle, Hi/Lo unchanged, no Done.
  - A following MTLO 0x5 in IDLE -> Lo=0x5 after one edge.
- Assert Rst at cycle 20 of a MULT -> Hi=Lo=0, Busy=0 immediately. A new DIVU 50/3 after release -> Lo=16, Hi=2.
